// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud helper.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } rx_state_t;

   // Rounded clock cycles per bit for a given clock and baud rate.
   function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered empty/full/count flags.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok_c;
   logic             push_ok_c;
   logic [CW-1:0]    count_nxt;

   // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
   assign pop_ok_c  = pop & ~empty;
   assign push_ok_c = push & (~full | pop_ok_c);
   assign dout      = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({push_ok_c, pop_ok_c})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push_ok_c) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok_c) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         empty <= (count_nxt == CW'(0));
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with input synchronizer, mid-bit sampling FSM and a FWFT byte FIFO
// presented on a valid/ready interface, plus frame-error pulse and sticky overrun flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = clks_per_bit(24_000_000, 115_200),
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic                          sys_clk,
   input  logic                          reset_n,
   input  logic                          rxd,
   output logic [UART_DATA_BITS-1:0]     rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
   localparam int unsigned HALF   = CLKS_PER_BIT / 2;

   logic [SYNC_STAGES-1:0]    sync_q;
   logic                      rxd_s;
   rx_state_t                 state;
   rx_state_t                 state_nxt;
   logic [BAUD_W-1:0]         baud_cnt;
   logic [BIT_W-1:0]          bit_idx;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      bit_tick_c;
   logic                      start_c;
   logic                      shift_c;
   logic                      push_c;
   logic                      frame_err_c;
   logic                      fifo_full;
   logic                      fifo_empty;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '1;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end

   assign rxd_s      = sync_q[SYNC_STAGES-1];
   assign bit_tick_c = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_c     = 1'b0;
      shift_c     = 1'b0;
      push_c      = 1'b0;
      frame_err_c = 1'b0;
      case (state)
         IDLE: begin
            if (!rxd_s) begin
               state_nxt = START;
               start_c   = 1'b1;
            end
         end
         START: begin
            if (bit_tick_c) state_nxt = rxd_s ? IDLE : DATA;
         end
         DATA: begin
            if (bit_tick_c) begin
               shift_c = 1'b1;
               if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) state_nxt = STOP;
            end
         end
         STOP: begin
            // Leaving at mid-stop lets a back-to-back start edge be seen in time.
            if (bit_tick_c) begin
               if (rxd_s) begin
                  push_c    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  frame_err_c = 1'b1;
                  state_nxt   = BRK;
               end
            end
         end
         BRK: begin
            if (rxd_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Baud/bit counters and data shifter; the start load lands the first tick at mid start bit.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift_q  <= '0;
      end else begin
         if (start_c) begin
            baud_cnt <= BAUD_W'(CLKS_PER_BIT - HALF);
         end else if (state == START || state == DATA || state == STOP) begin
            baud_cnt <= bit_tick_c ? '0 : baud_cnt + BAUD_W'(1);
         end else begin
            baud_cnt <= '0;
         end
         if (start_c) begin
            bit_idx <= '0;
         end else if (shift_c) begin
            bit_idx          <= bit_idx + BIT_W'(1);
            shift_q[bit_idx] <= rxd_s;
         end
      end
   end

   // Overrun only when a good byte meets a full FIFO with no pop to make room; set beats clear.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frame_err_c;
         if (push_c && fifo_full && !rx_ready) overrun <= 1'b1;
         else if (err_clr)                     overrun <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst_n (reset_n),
      .push  (push_c),
      .din   (shift_q),
      .full  (fifo_full),
      .pop   (rx_ready),
      .dout  (rx_data),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rx_valid = ~fifo_empty;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Fabric-side UART receiver that decodes the serial stream driven by the EMPU's uart0_txd pin. Frame format is 8N1, LSB first, idle high.
Received bytes are buffered in a small first-word-fall-through FIFO and presented on a valid/ready interface to fabric logic (GPIO/command decoders).
Framing and overrun errors are reported to that logic.

Parameters:
CLKS_PER_BIT, 208, sys_clk cycles per bit (24 MHz / 115200); minimum 4
FIFO_DEPTH, 16, FIFO entries; power of two, at least 2
SYNC_STAGES, 2, number of rxd synchronizer flops; at least 2

Ports:
sys_clk  input  1  system clock; all logic on the rising edge
reset_n  input  1  asynchronous active-low reset
rxd  input  1  serial input, asynchronous to sys_clk
rx_data  output  8  head-of-FIFO byte; valid only while rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts rx_data when rx_valid=1
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  output  1  one-cycle pulse when the stop bit samples 0
overrun  output  1  sticky; set when a good byte arrives while the FIFO is full
err_clr  input  1  synchronous clear of overrun

Behaviour:
- Clock and reset: one clock, sys_clk. reset_n is asynchronous, active-low.
- Reset values:
  - Synchronizer flops = 1.
  - FSM = IDLE; bit counter = 0; baud counter = 0.
  - FIFO empty: rx_valid=0, fifo_count=0, rx_data=0x00.
  - frame_err=0, overrun=0.
- Reset mid-frame: the partial byte is discarded.
- Synchronization: rxd passes through SYNC_STAGES flops, giving rxd_s. All decisions use rxd_s only.
- Sampling: a baud counter counts 0..CLKS_PER_BIT-1. A sample is taken when the count reaches its terminal value.
- FSM states: IDLE, START, DATA, STOP, BRK.
  - IDLE: rxd_s=0 -> START, with the baud counter loaded to sample after CLKS_PER_BIT/2 cycles (integer divide).
  - START, at mid-bit: rxd_s=0 -> DATA (bit index 0, counter reloaded to a full bit). rxd_s=1 -> glitch rejected, return to IDLE with no flags raised.
  - DATA: every CLKS_PER_BIT cycles, shift rxd_s into bit[index], LSB first. After index 7 is sampled -> STOP.
  - STOP, at mid stop bit:
    - rxd_s=1 -> push the byte (if not full, or see the full-FIFO rules below) and go to IDLE. IDLE is entered at mid-stop so that back-to-back frames are received.
    - rxd_s=0 -> pulse frame_err for 1 cycle, drop the byte, go to BRK.
  - BRK: stay until rxd_s=1, then go to IDLE. A line held low (break) produces exactly one frame_err.
- Latency: the push takes effect on the cycle after the stop sample. rx_valid rises on that cycle if the FIFO was empty.
- FIFO behaviour:
  - First-word-fall-through: rx_data = mem[rd_ptr] whenever rx_valid=1.
  - Pop = rx_valid & rx_ready. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- FIFO boundary cases:
  - Push with FIFO full and no pop in the same cycle: byte dropped, overrun<=1, count unchanged.
  - Push with FIFO full and a pop in the same cycle: push accepted, count unchanged, no overrun.
  - Push and pop together at count=0: impossible, since rx_valid=0.
  - Push and pop together otherwise: count unchanged.
  - rx_ready while empty: ignored.
- Error clearing: err_clr=1 clears overrun on the next edge. If an overrun event occurs in the same cycle, set wins.
- Outputs: all outputs are registered or driven directly from registers/memory. No combinational path from rx_ready to any output other than through registers.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, BRK).
  - UART_DATA_BITS=8.
  - Helper function clks_per_bit(clk_hz, baud) for top-level parameter computation.
- Sub-module sync_fifo:
  - Parameters: WIDTH=8, DEPTH.
  - Ports: push/din/full, pop/dout/empty, count.
  - Reused later by the planned uart_tx block.
- uart_rx_fifo contains the synchronizer, the FSM/baud/bit counters, and the overrun/frame logic.

Test Plan:
1. Send 0xA5 at CLKS_PER_BIT=208, rx_ready=1 -> rx_valid pulses once with rx_data=0xA5, about 9.5 bit times plus SYNC_STAGES+1 cycles after the start edge. frame_err=0.
2. Drive rxd low for 50 cycles, then high -> FSM returns to IDLE. No push, no frame_err, fifo_count stays 0.
3. Send 0x3C with stop bit=0, held low for 3 bit times -> exactly one frame_err pulse, no push. The following valid frame 0x81 is received correctly.
4. rx_ready=0, send 17 bytes 0x00..0x10 -> fifo_count=16, overrun=1. Draining yields 0x00..0x0F in order and 0x10 is absent. err_clr clears overrun.
5. FIFO full, assert a single-cycle pop exactly on the push cycle of byte 0x55 -> fifo_count stays 16, overrun stays 0, and 0x55 is the last byte drained.
6. Assert reset_n low in the middle of the DATA bits of 0xF0, then release -> all outputs at reset values. The next frame 0x12 is received cleanly with no spurious byte.
